// File: rtl/stream_mux_arb.sv
// N:1 streaming multiplexer with run-time selectable arbitration (fixed, round-robin, forced)
// feeding a one-entry registered output stage with valid/ready handshakes.

module stream_mux_arb_lane #(
    parameter int WIDTH = 5
) (
    input  logic             i_grant,
    input  logic             i_can_load,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_xfer,
    output logic [WIDTH-1:0] o_data
);
    assign o_ready = i_grant & i_can_load & ~i_rst;
    assign o_xfer  = o_ready & i_valid;
    // Masked so the top can OR-reduce lanes instead of building a wide mux.
    assign o_data  = {WIDTH{o_xfer}} & i_data;
endmodule

module stream_mux_arb #(
    parameter  int WIDTH    = 5,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CHANNELS*WIDTH-1:0] i_in_data,
    input  logic [CHANNELS-1:0]       i_in_valid,
    output logic [CHANNELS-1:0]       o_in_ready,
    input  logic [1:0]                i_mode,
    input  logic [SEL_W-1:0]          i_force_sel,
    output logic [WIDTH-1:0]          o_out_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [SEL_W-1:0]          o_out_chan
);
    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_FORCE = 2'b10;

    logic [WIDTH-1:0]                r_out_data;
    logic                            r_out_valid;
    logic [SEL_W-1:0]                r_out_chan;
    logic [SEL_W-1:0]                r_rr_ptr;

    logic                            w_can_load;
    logic [CHANNELS-1:0]             w_hi_mask;
    logic [CHANNELS-1:0]             w_force_hit;
    logic [CHANNELS-1:0]             w_low_all;
    logic [CHANNELS-1:0]             w_low_hi;
    logic [CHANNELS-1:0]             w_grant;
    logic [CHANNELS-1:0]             w_xfer;
    logic [CHANNELS-1:0][WIDTH-1:0]  w_lane_data;
    logic [WIDTH-1:0]                w_sel_data;
    logic [SEL_W-1:0]                w_xfer_idx;
    logic                            w_any_xfer;

    function automatic logic [CHANNELS-1:0] f_lowest(input logic [CHANNELS-1:0] v);
        logic [CHANNELS-1:0] g;
        g = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (v[i] && g == '0) g[i] = 1'b1;
        return g;
    endfunction

    assign w_can_load = ~r_out_valid | i_out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            // Round-robin scans channels at or above the pointer first, then wraps to the rest.
            assign w_hi_mask[gi]   = (SEL_W'(gi) >= r_rr_ptr);
            assign w_force_hit[gi] = (SEL_W'(gi) == i_force_sel) & i_in_valid[gi];

            stream_mux_arb_lane #(.WIDTH(WIDTH)) u_lane (
                .i_grant    (w_grant[gi]),
                .i_can_load (w_can_load),
                .i_rst      (i_rst),
                .i_valid    (i_in_valid[gi]),
                .i_data     (i_in_data[gi*WIDTH +: WIDTH]),
                .o_ready    (o_in_ready[gi]),
                .o_xfer     (w_xfer[gi]),
                .o_data     (w_lane_data[gi])
            );
        end
    endgenerate

    always_comb begin
        w_low_all = f_lowest(i_in_valid);
        w_low_hi  = f_lowest(i_in_valid & w_hi_mask);
        case (i_mode)
            MODE_RR:    w_grant = (w_low_hi != '0) ? w_low_hi : w_low_all;
            MODE_FORCE: w_grant = w_force_hit;
            default:    w_grant = w_low_all;
        endcase
    end

    always_comb begin
        w_xfer_idx = '0;
        w_sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_xfer[i]) w_xfer_idx = SEL_W'(i);
            w_sel_data = w_sel_data | w_lane_data[i];
        end
    end

    assign w_any_xfer = |w_xfer;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_any_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_chan  <= w_xfer_idx;
            r_out_valid <= 1'b1;
            r_rr_ptr    <= (w_xfer_idx == SEL_W'(CHANNELS-1)) ? '0 : w_xfer_idx + SEL_W'(1);
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_chan  = r_out_chan;
endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: cycle model feeds a {chan,data} scoreboard, plus directed checks.

module tb_stream_mux_arb;
    localparam int W  = 5;
    localparam int N  = 4;
    localparam int SW = 2;

    logic            clk;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [1:0]      mode;
    logic [SW-1:0]   force_sel;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_chan;

    int n_checks = 0;
    int n_errors = 0;

    logic [SW+W-1:0] sb[$];
    int              m_ptr  = 0;
    logic            m_oval = 1'b0;
    int              m_pick;
    int              m_rdy;
    logic [SW+W-1:0] m_ent;

    stream_mux_arb #(.WIDTH(W), .CHANNELS(N)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_mode      (mode),
        .i_force_sel (force_sel),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_chan  (out_chan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] md, input logic [N-1:0] v, input int ptr, input int fs);
        if (md == 2'b10) return (((v >> fs) & 1) != 0) ? fs : -1;
        if (md == 2'b01) begin
            for (int k = 0; k < N; k++)
                if (((v >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
            return -1;
        end
        for (int k = 0; k < N; k++)
            if (((v >> k) & 1) != 0) return k;
        return -1;
    endfunction

    // Reference model: consume held word, then decide this cycle's grant and push it.
    always @(negedge clk) begin
        if (rst) begin
            m_ptr  = 0;
            m_oval = 1'b0;
            sb.delete();
            chk("m.rst.rdy", 32'(in_ready), 0);
            chk("m.rst.oval", 32'(out_valid), 0);
        end else begin
            chk("m.oval", 32'(out_valid), 32'(m_oval));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb.underflow", 32'(sb.size()), 1);
                end else begin
                    m_ent = sb.pop_front();
                    chk("sb.data", 32'(out_data), 32'(m_ent[W-1:0]));
                    chk("sb.chan", 32'(out_chan), 32'(m_ent[SW+W-1:W]));
                end
            end
            m_pick = pick(mode, in_valid, m_ptr, int'(force_sel));
            m_rdy  = (m_pick >= 0 && (!m_oval || out_ready)) ? (1 << m_pick) : 0;
            chk("m.rdy", 32'(in_ready), m_rdy);
            if (m_rdy != 0) begin
                sb.push_back({SW'(m_pick), in_data[m_pick*W +: W]});
                m_ptr  = (m_pick + 1) % N;
                m_oval = 1'b1;
            end else if (out_ready) begin
                m_oval = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int d0, input int d1, input int d2, input int d3);
        in_data = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    task automatic exp_out(input string tag, input int ch, input int d);
        chk({tag, ".v"}, 32'(out_valid), 1);
        chk({tag, ".c"}, 32'(out_chan), ch);
        chk({tag, ".d"}, 32'(out_data), d);
    endtask

    initial begin
        int ec[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; mode = 2'b01; force_sel = '0; in_valid = 4'hF; out_ready = 1'b1;
        set_d(1, 2, 3, 4);
        repeat (2) cyc();
        @(negedge clk);
        chk("rst.v", 32'(out_valid), 0);
        chk("rst.d", 32'(out_data), 0);
        chk("rst.rdy", 32'(in_ready), 0);

        // Round robin from reset, including pointer wrap
        cyc(); rst = 1'b0;
        @(negedge clk); chk("rr.first", 32'(in_ready), 1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk); exp_out("rr", ec[k], ec[k] + 1);
        end

        // Backpressure for 3 cycles, then release with no bubble
        for (int k = 0; k < 3; k++) begin
            cyc(); out_ready = 1'b0;
            @(negedge clk); exp_out("bp", 1, 2); chk("bp.rdy", 32'(in_ready), 0);
        end
        cyc(); out_ready = 1'b1;
        @(negedge clk); exp_out("bp.rel", 1, 2); chk("bp.rel.rdy", 32'(in_ready), 4);
        cyc(); in_valid = 4'b0010;
        @(negedge clk); exp_out("nobubble", 2, 3); chk("rr.p3.rdy", 32'(in_ready), 2);

        // Mode switch with rr_ptr=2: fixed grabs ch0, rr resumes at 1
        cyc(); mode = 2'b00; in_valid = 4'hF;
        @(negedge clk); exp_out("sw.prev", 1, 2); chk("sw.fix.rdy", 32'(in_ready), 1);
        cyc(); mode = 2'b01;
        @(negedge clk); exp_out("sw.fix", 0, 1); chk("sw.rr.rdy", 32'(in_ready), 2);

        // Forced channel
        cyc(); mode = 2'b10; force_sel = 2'd2;
        @(negedge clk); exp_out("sw.rr", 1, 2); chk("frc.rdy", 32'(in_ready), 4);
        cyc(); in_valid = 4'b1011;
        @(negedge clk); exp_out("frc", 2, 3); chk("frc.none.rdy", 32'(in_ready), 0);
        cyc();
        @(negedge clk);
        chk("frc.drain.v", 32'(out_valid), 0);
        chk("frc.hold.d", 32'(out_data), 3);
        chk("frc.hold.c", 32'(out_chan), 2);

        // Fixed priority
        cyc(); mode = 2'b00; in_valid = 4'b1010; set_d(0, 12, 0, 6);
        @(negedge clk); chk("fix.rdy1", 32'(in_ready), 2);
        cyc(); in_valid = 4'b1000;
        @(negedge clk); exp_out("fix.c1", 1, 12); chk("fix.rdy3", 32'(in_ready), 8);
        cyc(); in_valid = 4'b0000;
        @(negedge clk); exp_out("fix.c3", 3, 6);
        cyc(); mode = 2'b11; in_valid = 4'b0110; set_d(0, 12, 3, 0);
        @(negedge clk); chk("m11.drain.v", 32'(out_valid), 0); chk("m11.rdy", 32'(in_ready), 2);
        cyc(); in_valid = 4'b0000;
        @(negedge clk); exp_out("m11", 1, 12);

        // Reset mid-stream, asserted away from the clock edge
        cyc(); mode = 2'b01; in_valid = 4'hF; set_d(1, 2, 3, 4);
        cyc();
        @(negedge clk); chk("mid.v", 32'(out_valid), 1);
        cyc();
        @(negedge clk); #1; rst = 1'b1; #1;
        chk("mid.rst.v", 32'(out_valid), 0);
        chk("mid.rst.d", 32'(out_data), 0);
        chk("mid.rst.rdy", 32'(in_ready), 0);
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk); chk("mid.rel.rdy", 32'(in_ready), 1);

        // Random traffic checked against the model
        repeat (300) begin
            cyc();
            in_valid  = 4'($urandom);
            mode      = 2'($urandom);
            force_sel = 2'($urandom);
            out_ready = ($urandom % 4) != 0;
            in_data   = 20'($urandom);
        end
        cyc(); in_valid = 4'b0000; out_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk); chk("sb.empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
